// File: rtl/pwm_fade_ctrl.sv
// Brightness envelope generator: ramps the PWM duty value up, holds it at full,
// ramps it down and holds it at off, advancing one step per prescaler tick.
module pwm_fade_ctrl #(
    parameter int unsigned PWM_INTERVAL  = 1200,
    parameter int unsigned STEP_INTERVAL = 12000,
    parameter int unsigned STEPS         = 200,
    parameter int unsigned HOLD_STEPS    = 50
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            enable,
    output logic [$clog2(PWM_INTERVAL)-1:0] pwm_value,
    output logic [1:0]                      fade_state,
    output logic                            cycle_done
);

    localparam int unsigned VW        = $clog2(PWM_INTERVAL);
    localparam int unsigned PW        = (STEP_INTERVAL > 1) ? $clog2(STEP_INTERVAL) : 1;
    localparam int unsigned HW        = (HOLD_STEPS > 1) ? $clog2(HOLD_STEPS) : 1;
    localparam int unsigned STEP_SIZE = PWM_INTERVAL / STEPS;

    typedef enum logic [1:0] {
        RAMP_UP   = 2'd0,
        HOLD_HIGH = 2'd1,
        RAMP_DOWN = 2'd2,
        HOLD_LOW  = 2'd3
    } state_t;

    state_t          state, state_nxt;
    logic [PW-1:0]   presc, presc_nxt;
    logic [HW-1:0]   hold_cnt, hold_nxt;
    logic [VW-1:0]   pwm_nxt;
    logic            done_nxt;
    logic            tick;
    logic [VW-1:0]   pwm_up, pwm_down;
    logic            hold_last;

    assign tick       = enable && (presc == PW'(STEP_INTERVAL - 1));
    assign pwm_up     = pwm_value + VW'(STEP_SIZE);
    assign pwm_down   = pwm_value - VW'(STEP_SIZE);
    assign hold_last  = (hold_cnt == HW'(HOLD_STEPS - 1));
    assign fade_state = state;

    // State, counters and outputs all register together; reset wins every cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= RAMP_UP;
            presc      <= '0;
            hold_cnt   <= '0;
            pwm_value  <= '0;
            cycle_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            presc      <= presc_nxt;
            hold_cnt   <= hold_nxt;
            pwm_value  <= pwm_nxt;
            cycle_done <= done_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        presc_nxt = presc;
        hold_nxt  = hold_cnt;
        pwm_nxt   = pwm_value;
        done_nxt  = 1'b0;

        if (enable) begin
            presc_nxt = tick ? '0 : presc + PW'(1);
        end

        if (tick) begin
            case (state)
                RAMP_UP: begin
                    pwm_nxt = pwm_up;
                    if (pwm_up == VW'(PWM_INTERVAL)) begin
                        state_nxt = HOLD_HIGH;
                        hold_nxt  = '0;
                    end
                end
                HOLD_HIGH: begin
                    if (hold_last) begin
                        state_nxt = RAMP_DOWN;
                        hold_nxt  = '0;
                    end else begin
                        hold_nxt = hold_cnt + HW'(1);
                    end
                end
                RAMP_DOWN: begin
                    pwm_nxt = pwm_down;
                    if (pwm_down == '0) begin
                        state_nxt = HOLD_LOW;
                        hold_nxt  = '0;
                    end
                end
                HOLD_LOW: begin
                    if (hold_last) begin
                        state_nxt = RAMP_UP;
                        hold_nxt  = '0;
                        done_nxt  = 1'b1;
                    end else begin
                        hold_nxt = hold_cnt + HW'(1);
                    end
                end
                default: begin
                    state_nxt = RAMP_UP;
                    pwm_nxt   = '0;
                    hold_nxt  = '0;
                end
            endcase
        end
    end

    // Divisibility of PWM_INTERVAL by STEPS keeps the ramp inside 0..PWM_INTERVAL.
    a_pwm_range: assert property (@(posedge clk) pwm_value <= VW'(PWM_INTERVAL));

endmodule
